// File: rtl/hist_pkg.sv
// Shared types and default sizing for the histogram engine.
package hist_pkg;

  localparam int unsigned DEF_LANES    = 8;
  localparam int unsigned DEF_LANE_W   = 16;
  localparam int unsigned DEF_BIN_BITS = 4;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned TOTAL_W      = 32;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    ACCUM = 2'd2
  } state_e;

endpackage

// File: rtl/hist_bin_ram.sv
// Bin counter storage: one write port, one registered read port.
// A read and a write to the same address on one edge return the new data.
module hist_bin_ram #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Write-first bypass keeps back-to-back increments of one bin exact.
  always_ff @(posedge clk_i) begin
    if (rst_i)                            rdata_q <= '0;
    else if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
    else                                  rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/histogram_engine.sv
// Streaming histogram: bins one lane per cycle into a counter RAM with
// saturating counts, a saturating sample total and a bin-clearing sweep.
module histogram_engine
  import hist_pkg::*;
#(
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned LANE_W   = DEF_LANE_W,
  parameter int unsigned BIN_BITS = DEF_BIN_BITS,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                      wrclk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  input  logic                      clear,
  output logic                      busy,
  input  logic                      rd_en,
  input  logic [BIN_BITS-1:0]       rd_addr,
  output logic [CNT_W-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [TOTAL_W-1:0]        total,
  output logic                      sat
);

  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BIN_BITS-1:0] LAST_BIN  = BIN_BITS'(2**BIN_BITS - 1);
  localparam logic [LIDX_W-1:0]   LAST_LANE = LIDX_W'(LANES - 1);

  state_e              state_q, state_d;
  logic [BIN_BITS-1:0] sweep_q, sweep_d;
  logic [LIDX_W-1:0]   lane_q, lane_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                clr_pend_q, clr_pend_d;
  logic                wr_pend_q, wr_pend_d;
  logic [BIN_BITS-1:0] wr_bin_q, wr_bin_d;
  logic [TOTAL_W-1:0]  total_q, total_d;
  logic                sat_q, sat_d;
  logic                in_ready_q, busy_q, rd_valid_q;

  logic [LANE_W-1:0]   lane_sample;
  logic [BIN_BITS-1:0] lane_bin;
  logic                ram_we;
  logic [BIN_BITS-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]    ram_wdata, ram_rdata, inc_val;
  logic                at_max;

  // Current lane and its clamped bin index.
  always_comb begin
    lane_sample = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LIDX_W'(i)) lane_sample = data_q[i*LANE_W +: LANE_W];
    end
    if ((lane_sample >> BIN_BITS) != '0) lane_bin = LAST_BIN;
    else                                 lane_bin = lane_sample[BIN_BITS-1:0];
  end

  assign at_max  = (ram_rdata == '1);
  assign inc_val = at_max ? ram_rdata : ram_rdata + CNT_W'(1);

  // Lane bins are read in ACCUM and written back, incremented, one cycle later.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    lane_d     = lane_q;
    data_d     = data_q;
    clr_pend_d = clr_pend_q;
    wr_pend_d  = 1'b0;
    wr_bin_d   = wr_bin_q;
    total_d    = total_q;
    sat_d      = sat_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_bin_q;
    ram_wdata  = inc_val;
    ram_raddr  = rd_addr;

    if (wr_pend_q && (state_q != CLEAR)) begin
      ram_we = 1'b1;
      if (at_max) sat_d = 1'b1;
    end

    case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = sweep_q;
        ram_wdata = '0;
        if (clear)                    sweep_d = '0;
        else if (sweep_q == LAST_BIN) state_d = IDLE;
        else                          sweep_d = sweep_q + BIN_BITS'(1);
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          sweep_d = '0;
          total_d = '0;
          sat_d   = 1'b0;
        end else if (in_valid) begin
          state_d = ACCUM;
          data_d  = in_data;
          lane_d  = '0;
        end
      end
      ACCUM: begin
        ram_raddr = lane_bin;
        wr_pend_d = 1'b1;
        wr_bin_d  = lane_bin;
        if (total_q != '1) total_d = total_q + TOTAL_W'(1);
        if (clear) clr_pend_d = 1'b1;
        if (lane_q == LAST_LANE) begin
          if (clr_pend_q || clear) begin
            state_d    = CLEAR;
            sweep_d    = '0;
            total_d    = '0;
            sat_d      = 1'b0;
            clr_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lane_d = lane_q + LIDX_W'(1);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge wrclk) begin
    if (rst) begin
      state_q    <= CLEAR;
      sweep_q    <= '0;
      lane_q     <= '0;
      data_q     <= '0;
      clr_pend_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_bin_q   <= '0;
      total_q    <= '0;
      sat_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      lane_q     <= lane_d;
      data_q     <= data_d;
      clr_pend_q <= clr_pend_d;
      wr_pend_q  <= wr_pend_d;
      wr_bin_q   <= wr_bin_d;
      total_q    <= total_d;
      sat_q      <= sat_d;
      in_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d != IDLE);
      rd_valid_q <= rd_en && (state_q == IDLE);
    end
  end

  hist_bin_ram #(
    .AW (BIN_BITS),
    .DW (CNT_W)
  ) u_ram (
    .clk_i   (wrclk),
    .rst_i   (rst),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = ram_rdata;
  assign total    = total_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine: default instance plus a CNT_W=4
// instance for counter saturation.
module tb_histogram_engine;

  logic wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_clear, a_busy, a_rd_en, a_rd_valid, a_sat;
  logic [127:0] a_in_data;
  logic [3:0]   a_rd_addr;
  logic [15:0]  a_rd_data;
  logic [31:0]  a_total;

  logic         b_in_valid, b_in_ready, b_clear, b_busy, b_rd_en, b_rd_valid, b_sat;
  logic [127:0] b_in_data;
  logic [3:0]   b_rd_addr;
  logic [3:0]   b_rd_data;
  logic [31:0]  b_total;

  histogram_engine dut (
    .wrclk(wrclk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .clear(a_clear), .busy(a_busy), .rd_en(a_rd_en),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .total(a_total), .sat(a_sat)
  );

  histogram_engine #(.CNT_W(4)) dut4 (
    .wrclk(wrclk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .clear(b_clear), .busy(b_busy), .rd_en(b_rd_en),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .total(b_total), .sat(b_sat)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_in_ready : a_in_ready;
  endfunction

  task automatic wait_ready(input bit sel, input string tag, output int cycles);
    cycles = 0;
    while (!rdy(sel) && cycles < 100) begin
      @(negedge wrclk);
      cycles++;
    end
    if (!rdy(sel)) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Accepts one word; returns cycles from acceptance until in_ready returns.
  task automatic send(input bit sel, input logic [127:0] d, output int cycles);
    int c;
    wait_ready(sel, "send_pre", c);
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; end
    else     begin a_in_valid = 1'b1; a_in_data = d; end
    @(negedge wrclk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    wait_ready(sel, "send_post", cycles);
  endtask

  task automatic read_bin(input bit sel, input logic [3:0] bin,
                          output logic [31:0] val, output logic vld);
    if (sel) begin b_rd_en = 1'b1; b_rd_addr = bin; end
    else     begin a_rd_en = 1'b1; a_rd_addr = bin; end
    @(negedge wrclk);
    vld = sel ? b_rd_valid : a_rd_valid;
    val = sel ? 32'(b_rd_data) : 32'(a_rd_data);
    a_rd_en = 1'b0;
    b_rd_en = 1'b0;
  endtask

  task automatic check_bins(input bit sel, input string tag, input logic [31:0] exp [16]);
    logic [31:0] v;
    logic        vld;
    for (int i = 0; i < 16; i++) begin
      read_bin(sel, 4'(i), v, vld);
      chk($sformatf("%s_vld%0d", tag, i), 32'(vld), 32'd1);
      chk($sformatf("%s_bin%0d", tag, i), v, exp[i]);
    end
  endtask

  logic [31:0]  exp_bins [16];
  logic [127:0] word;
  logic [31:0]  v;
  logic         vld;
  int           c;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_clear = 0; a_rd_en = 0; a_rd_addr = '0;
    b_in_valid = 0; b_in_data = '0; b_clear = 0; b_rd_en = 0; b_rd_addr = '0;
    repeat (3) @(negedge wrclk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_busy",     32'(a_busy),     32'd1);
    chk("rst_rd_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_rd_data",  32'(a_rd_data),  32'd0);
    chk("rst_total",    a_total,         32'd0);
    chk("rst_sat",      32'(a_sat),      32'd0);
    rst = 1'b0;

    // Post-reset sweep takes exactly 16 cycles
    repeat (15) @(negedge wrclk);
    chk("sweep15_busy", 32'(a_busy), 32'd1);
    @(negedge wrclk);
    chk("sweep16_busy",     32'(a_busy),     32'd0);
    chk("sweep16_in_ready", 32'(a_in_ready), 32'd1);
    chk("sweep16_total",    a_total,         32'd0);
    foreach (exp_bins[i]) exp_bins[i] = 32'd0;
    check_bins(1'b0, "init", exp_bins);

    // Mixed-bin word
    word = 128'h000C000F00050001000B00030008000A;
    send(1'b0, word, c);
    chk("mix_accum_cycles", 32'(c), 32'd8);
    foreach (exp_bins[i]) exp_bins[i] = 32'd0;
    exp_bins[1] = 1; exp_bins[3] = 1; exp_bins[5] = 1; exp_bins[8] = 1;
    exp_bins[10] = 1; exp_bins[11] = 1; exp_bins[12] = 1; exp_bins[15] = 1;
    check_bins(1'b0, "mix", exp_bins);
    chk("mix_total", a_total, 32'd8);

    // Clear and in_valid together: clear wins, word dropped
    a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = {8{16'h0003}};
    @(negedge wrclk);
    a_clear = 1'b0; a_in_valid = 1'b0;
    chk("clrwin_total",    a_total,         32'd0);
    chk("clrwin_in_ready", 32'(a_in_ready), 32'd0);
    wait_ready(1'b0, "clrwin", c);
    chk("clrwin_sweep_cycles", 32'(c), 32'd16);

    // Same bin back to back, two words
    send(1'b0, {8{16'h0003}}, c);
    send(1'b0, {8{16'h0003}}, c);
    foreach (exp_bins[i]) exp_bins[i] = 32'd0;
    exp_bins[3] = 16;
    check_bins(1'b0, "rep3", exp_bins);
    chk("rep3_total", a_total,    32'd16);
    chk("rep3_sat",   32'(a_sat), 32'd0);

    // Clamp of out-of-range samples into the top bin
    word = {16'h000E, 16'h000E, 16'h000E, 16'h000E, 16'h0000, 16'h000F, 16'hFFFF, 16'h0010};
    send(1'b0, word, c);
    exp_bins[0] = 1; exp_bins[14] = 4; exp_bins[15] = 3;
    check_bins(1'b0, "clamp", exp_bins);
    chk("clamp_total", a_total, 32'd24);

    // Clear during ACCUM is deferred; reads outside IDLE are refused
    wait_ready(1'b0, "defer_pre", c);
    a_in_valid = 1'b1; a_in_data = {8{16'h0007}};
    @(negedge wrclk);
    a_in_valid = 1'b0;
    @(negedge wrclk);
    a_clear = 1'b1; a_rd_en = 1'b1; a_rd_addr = 4'd3;
    @(negedge wrclk);
    a_clear = 1'b0; a_rd_en = 1'b0;
    chk("defer_rd_accum", 32'(a_rd_valid), 32'd0);
    repeat (7) @(negedge wrclk);
    chk("defer_busy",  32'(a_busy), 32'd1);
    chk("defer_total", a_total,     32'd0);
    a_rd_en = 1'b1; a_rd_addr = 4'd3;
    @(negedge wrclk);
    a_rd_en = 1'b0;
    chk("defer_rd_clear",  32'(a_rd_valid), 32'd0);
    chk("defer_in_ready",  32'(a_in_ready), 32'd0);
    wait_ready(1'b0, "defer", c);
    chk("defer_sweep_cycles", 32'(c), 32'd14);
    foreach (exp_bins[i]) exp_bins[i] = 32'd0;
    check_bins(1'b0, "defer", exp_bins);
    chk("defer_sat", 32'(a_sat), 32'd0);

    // Reset in the middle of ACCUM discards the word
    a_in_valid = 1'b1; a_in_data = {8{16'h0005}};
    @(negedge wrclk);
    a_in_valid = 1'b0;
    repeat (2) @(negedge wrclk);
    rst = 1'b1;
    @(negedge wrclk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(a_in_ready), 32'd0);
    chk("midrst_busy",     32'(a_busy),     32'd1);
    chk("midrst_total",    a_total,         32'd0);
    wait_ready(1'b0, "midrst", c);
    chk("midrst_sweep_cycles", 32'(c), 32'd16);
    check_bins(1'b0, "midrst", exp_bins);

    // Narrow counters: 16 hits on bin 2 saturate at 15
    send(1'b1, {8{16'h0002}}, c);
    read_bin(1'b1, 4'd2, v, vld);
    chk("n4_half_bin2", v, 32'd8);
    chk("n4_half_sat",  32'(b_sat), 32'd0);
    send(1'b1, {8{16'h0002}}, c);
    read_bin(1'b1, 4'd2, v, vld);
    chk("n4_bin2_vld", 32'(vld), 32'd1);
    chk("n4_bin2",     v, 32'd15);
    chk("n4_sat",      32'(b_sat), 32'd1);
    chk("n4_total",    b_total,    32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
